nanorv32_intc: RTL and testbench
================================

// Module: nanorv32_intc
// PURPOSE
//  Interrupt controller: the requester side of the core's irq/irq_ack handshake.
//  Collects NB_IRQ external sources and latches pending events.
//  Applies an enable mask and fixed priority, then presents one request to the
//  flow controller. Tracks the in-service interrupt until the core signals end of
//  service (reti executed). Single level only: no nesting. Sits beside the core.
//  Configured over a simple single-cycle register port.
// PARAMETERS
//  NB_IRQ        8   number of sources, 1..32
//  SYNC_STAGES   2   synchroniser depth on irq_src, >=2
// PORTS
//  clk        in   1       core clock, single clock domain
//  rst_n      in   1       asynchronous active-low reset
//  irq_src    in   NB_IRQ  raw external interrupt lines, async to clk
//  irq        out  1       request to core, registered
//  irq_ack    in   1       1-cycle pulse: core has accepted the request
//  irq_eoi    in   1       1-cycle pulse: core completed reti
//  irq_id     out  5       id of in-service source, valid while in_service
//  reg_sel    in   1       register access strobe
//  reg_write  in   1       1=write, 0=read (qualified by reg_sel)
//  reg_addr   in   4       byte address; [3:2] decoded, [1:0] ignored
//  reg_wdata  in   32      write data
//  reg_rdata  out  32      read data, valid with reg_ready
//  reg_ready  out  1       access done, 1 cycle after reg_sel
// BEHAVIOUR
//  Reset: irq=0, irq_id=0, reg_rdata=0, reg_ready=0.
//   All registers, sync flops and in_service are cleared.
//  Register map (bits above NB_IRQ read 0, writes ignored):
//   0x0 ENABLE   RW  per-source mask
//   0x4 PENDING  R / W1C  (W1C affects edge-mode bits only)
//   0x8 EDGE     RW  1=rising-edge latched, 0=level
//   0xC ACTIVE   R   [31]=in_service, [4:0]=irq_id; writes ignored
//  Register port:
//   - Every reg_sel cycle gives reg_ready=1 on the next cycle, with rdata valid then.
//   - rdata=0 on writes and when reg_ready=0. No back-to-back restriction.
//  Sources:
//   - src_s = irq_src after SYNC_STAGES flops.
//   - Edge mode: pending bit sets when src_s=1 and its previous value was 0.
//     It holds until acked or W1C.
//   - Level mode: pending bit = src_s, not latched.
//  Request:
//   - winner = lowest index with pending & ENABLE.
//   - irq_r <= |(pending & ENABLE) & ~in_service & ~accept.
//   - Latency (SYNC_STAGES=2): irq rises on the 4th clk edge after the edge that
//     first samples irq_src high.
//  Accept: when irq_ack & irq_r:
//   - in_service<=1 and irq_id<=winner.
//   - winner's pending bit clears if it is edge mode.
//   - irq drops on the next edge.
//   - irq_ack while irq_r=0 is ignored (no state change).
//  End of service: irq_eoi clears in_service. irq_eoi while not in_service is ignored.
//   - irq may re-assert on the edge after the eoi edge if anything is pending.
//  Boundary cases:
//   - New edge and clear (ack or W1C) on the same bit in the same cycle: set wins,
//     so no event is lost.
//   - ENABLE cleared: pending is retained, irq is recomputed next edge. An already
//     accepted id stays in service.
//   - EDGE changed: pending bit for that source clears, to avoid a stale latch.
//   - Level source dropping before ack: irq drops the next edge, no accept.
//     Core must tolerate this, as it samples irq each CONT cycle.
//   - irq_ack and irq_eoi in the same cycle: impossible by construction
//     (irq_r=0 while in_service); eoi is applied, ack is ignored.
//   - rst_n asserted mid-service: immediate return to reset values.
//     Pending events are discarded.
// STRUCTURE
//  Add to nanorv32_parameters.v:
//   NANORV32_INTC_ADDR_ENABLE/PENDING/EDGE/ACTIVE, NANORV32_INTC_ID_MSB=4,
//   NANORV32_INTC_ACTIVE_INSVC_BIT=31.
//  Sub-module nanorv32_intc_sync: parameterised WIDTH x SYNC_STAGES flop chain,
//   async reset to 0.
//  Top holds the edge detect, pending/enable/edge regs, priority encoder, accept
//   logic and register decode.
// TESTING
//  1. EDGE=0x01, ENABLE=0x01; pulse src[0] 1 cycle -> irq=1 at 4th edge.
//     Ack -> irq_id=0, ACTIVE=0x8000_0000, PENDING=0.
//  2. src[5] and src[2] both edge, enabled, rising together -> irq_id=2.
//     eoi -> irq re-asserts the next cycle; ack -> irq_id=5.
//  3. Level src[3] held high, ack then eoi while still high -> irq re-asserts.
//     Drop src[3] before ack -> irq=0, ack ignored, ACTIVE=0.
//  4. Edge src[1] pending, ENABLE=0 -> irq=0 and PENDING=0x02.
//     Set ENABLE=0x02 -> irq=1. W1C 0x02 -> PENDING=0, irq=0.
//  5. W1C of bit1 in the same cycle as a new src[1] edge -> PENDING[1]=1.
//     Ack and new edge on the same bit -> bit stays 1.
//  6. rst_n low during in_service with pending=0xFF -> all outputs 0 at once.
//     After release, ENABLE=0 and irq stays 0.

Source files
------------

// File: rtl/nanorv32_intc_pkg.sv
// Shared definitions for the nanorv32 interrupt controller: register map,
// ACTIVE register layout and the fixed-priority helper.
package nanorv32_intc_pkg;

    typedef enum logic [1:0] {
        INTC_ADDR_ENABLE  = 2'd0,
        INTC_ADDR_PENDING = 2'd1,
        INTC_ADDR_EDGE    = 2'd2,
        INTC_ADDR_ACTIVE  = 2'd3
    } intc_addr_e;

    localparam int INTC_ID_MSB           = 4;
    localparam int INTC_ACTIVE_INSVC_BIT = 31;

    // Index of the lowest set bit; lower index means higher priority.
    function automatic logic [INTC_ID_MSB:0] intc_lowest_set(input logic [31:0] v);
        logic [INTC_ID_MSB:0] id;
        id = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) begin
                id = 5'(i);
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/nanorv32_intc_sync.sv
// WIDTH-bit wide, STAGES-deep synchroniser chain for asynchronous inputs.
module nanorv32_intc_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_chain [STAGES];

    // Shift the raw inputs through the flop chain
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                r_chain[s] <= {WIDTH{1'b0}};
            end
        end else begin
            r_chain[0] <= i_d;
            for (int s = 1; s < STAGES; s++) begin
                r_chain[s] <= r_chain[s-1];
            end
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/nanorv32_intc.sv
// Interrupt controller: synchronises external sources, latches events, applies
// mask and fixed priority, and drives the irq/ack/eoi handshake with the core.
module nanorv32_intc
    import nanorv32_intc_pkg::*;
#(
    parameter int NB_IRQ      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NB_IRQ-1:0] i_irq_src,
    output logic              o_irq,
    input  logic              i_irq_ack,
    input  logic              i_irq_eoi,
    output logic [4:0]        o_irq_id,
    input  logic              i_reg_sel,
    input  logic              i_reg_write,
    input  logic [3:0]        i_reg_addr,
    input  logic [31:0]       i_reg_wdata,
    output logic [31:0]       o_reg_rdata,
    output logic              o_reg_ready
);

    logic [NB_IRQ-1:0]    w_src_s;
    logic [NB_IRQ-1:0]    r_src_prev;
    logic [NB_IRQ-1:0]    r_enable;
    logic [NB_IRQ-1:0]    r_edge;
    logic [NB_IRQ-1:0]    r_pend_lat;
    logic                 r_irq;
    logic                 r_in_service;
    logic [INTC_ID_MSB:0] r_irq_id;
    logic [31:0]          r_rdata;
    logic                 r_ready;

    logic [NB_IRQ-1:0]    w_rise;
    logic [NB_IRQ-1:0]    w_pending;
    logic [NB_IRQ-1:0]    w_req;
    logic [NB_IRQ-1:0]    w_ack_clr;
    logic [NB_IRQ-1:0]    w_w1c;
    logic [NB_IRQ-1:0]    w_edge_chg;
    logic [NB_IRQ-1:0]    w_lat_next;
    logic [31:0]          w_req_ext;
    logic [31:0]          w_rd_data;
    logic [INTC_ID_MSB:0] w_winner;
    logic                 w_any;
    logic                 w_accept;
    logic                 w_wr;
    logic                 w_wr_enable;
    logic                 w_wr_pending;
    logic                 w_wr_edge;
    logic                 w_unused;
    intc_addr_e           w_addr;

    nanorv32_intc_sync #(
        .WIDTH  (NB_IRQ),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_irq_src),
        .o_q     (w_src_s)
    );

    assign w_addr    = intc_addr_e'(i_reg_addr[3:2]);
    assign w_wr      = i_reg_sel & i_reg_write;
    assign w_unused  = ^{i_reg_addr[1:0], i_reg_wdata};

    // Level sources are transparent; only edge-mode bits are ever latched.
    assign w_rise    = w_src_s & ~r_src_prev;
    assign w_pending = r_pend_lat | (w_src_s & ~r_edge);
    assign w_req     = w_pending & r_enable;
    assign w_any     = |w_req;
    assign w_winner  = intc_lowest_set(w_req_ext);
    // An ack against a request that has already vanished is not an accept.
    assign w_accept  = i_irq_ack & r_irq & w_any;

    assign w_w1c      = w_wr_pending ? i_reg_wdata[NB_IRQ-1:0] : {NB_IRQ{1'b0}};
    assign w_edge_chg = w_wr_edge ? (i_reg_wdata[NB_IRQ-1:0] ^ r_edge) : {NB_IRQ{1'b0}};
    // A new edge beats a same-cycle clear; a mode change drops any stale latch.
    assign w_lat_next = ((r_pend_lat & ~(w_ack_clr | w_w1c)) | (w_rise & r_edge)) & ~w_edge_chg;

    // Zero-extend the request vector for the priority helper
    always_comb begin
        w_req_ext                = 32'd0;
        w_req_ext[NB_IRQ-1:0]    = w_req;
    end

    // One-hot clear of the winner's latch on accept
    always_comb begin
        w_ack_clr = {NB_IRQ{1'b0}};
        for (int i = 0; i < NB_IRQ; i++) begin
            w_ack_clr[i] = w_accept & (w_winner == 5'(i));
        end
    end

    // Register decode: write strobes and read mux
    always_comb begin
        w_wr_enable  = 1'b0;
        w_wr_pending = 1'b0;
        w_wr_edge    = 1'b0;
        w_rd_data    = 32'd0;
        case (w_addr)
            INTC_ADDR_ENABLE: begin
                w_wr_enable              = w_wr;
                w_rd_data[NB_IRQ-1:0]    = r_enable;
            end
            INTC_ADDR_PENDING: begin
                w_wr_pending             = w_wr;
                w_rd_data[NB_IRQ-1:0]    = w_pending;
            end
            INTC_ADDR_EDGE: begin
                w_wr_edge                = w_wr;
                w_rd_data[NB_IRQ-1:0]    = r_edge;
            end
            INTC_ADDR_ACTIVE: begin
                w_rd_data[INTC_ACTIVE_INSVC_BIT] = r_in_service;
                w_rd_data[INTC_ID_MSB:0]         = r_irq_id;
            end
            default: begin
                w_rd_data = 32'd0;
            end
        endcase
    end

    // Source history, configuration registers and pending latches
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_src_prev <= {NB_IRQ{1'b0}};
            r_pend_lat <= {NB_IRQ{1'b0}};
            r_enable   <= {NB_IRQ{1'b0}};
            r_edge     <= {NB_IRQ{1'b0}};
        end else begin
            r_src_prev <= w_src_s;
            r_pend_lat <= w_lat_next;
            if (w_wr_enable) begin
                r_enable <= i_reg_wdata[NB_IRQ-1:0];
            end
            if (w_wr_edge) begin
                r_edge <= i_reg_wdata[NB_IRQ-1:0];
            end
        end
    end

    // Request / in-service handshake with the core
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_irq        <= 1'b0;
            r_in_service <= 1'b0;
            r_irq_id     <= 5'd0;
        end else begin
            r_irq <= w_any & ~r_in_service & ~w_accept;
            if (w_accept) begin
                r_in_service <= 1'b1;
                r_irq_id     <= w_winner;
            end else if (i_irq_eoi && r_in_service) begin
                r_in_service <= 1'b0;
                r_irq_id     <= 5'd0;
            end
        end
    end

    // Register port response one cycle after the strobe
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ready <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_ready <= i_reg_sel;
            r_rdata <= (i_reg_sel && !i_reg_write) ? w_rd_data : 32'd0;
        end
    end

    assign o_irq       = r_irq;
    assign o_irq_id    = r_irq_id;
    assign o_reg_rdata = r_rdata;
    assign o_reg_ready = r_ready;

endmodule

// File: tb/tb_nanorv32_intc.sv
// Self-checking bench for nanorv32_intc: directed scenarios plus random traffic,
// all compared every cycle against a behavioural model of the controller.
module tb_nanorv32_intc;

    localparam int NB = 8;
    localparam int SS = 2;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] src   = 8'd0;
    logic          ack   = 1'b0;
    logic          eoi   = 1'b0;
    logic          sel   = 1'b0;
    logic          wr    = 1'b0;
    logic [3:0]    addr  = 4'd0;
    logic [31:0]   wdata = 32'd0;
    logic          irq;
    logic [4:0]    irq_id;
    logic [31:0]   rdata;
    logic          ready;
    logic [31:0]   rd_val;

    int n_cmp = 0;
    int n_bad = 0;

    nanorv32_intc #(.NB_IRQ(NB), .SYNC_STAGES(SS)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_irq_src   (src),
        .o_irq       (irq),
        .i_irq_ack   (ack),
        .i_irq_eoi   (eoi),
        .o_irq_id    (irq_id),
        .i_reg_sel   (sel),
        .i_reg_write (wr),
        .i_reg_addr  (addr),
        .i_reg_wdata (wdata),
        .o_reg_rdata (rdata),
        .o_reg_ready (ready)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [NB-1:0] m_sync [SS];
    logic [NB-1:0] m_prev  = 8'd0;
    logic [NB-1:0] m_lat   = 8'd0;
    logic [NB-1:0] m_en    = 8'd0;
    logic [NB-1:0] m_edge  = 8'd0;
    logic          m_irq   = 1'b0;
    logic          m_insvc = 1'b0;
    logic          m_ready = 1'b0;
    logic [4:0]    m_id    = 5'd0;
    logic [31:0]   m_rdata = 32'd0;

    function automatic int lowest(input logic [NB-1:0] v);
        for (int i = 0; i < NB; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_step();
        logic [NB-1:0] s, pend, nlat, w1c, chg;
        int  win;
        logic acc;
        if (!rst_n) begin
            for (int k = 0; k < SS; k++) m_sync[k] = 8'd0;
            m_prev = 8'd0; m_lat = 8'd0; m_en = 8'd0; m_edge = 8'd0;
            m_irq = 1'b0; m_insvc = 1'b0; m_ready = 1'b0; m_id = 5'd0; m_rdata = 32'd0;
            return;
        end
        s = m_sync[SS-1];
        for (int i = 0; i < NB; i++) pend[i] = m_edge[i] ? m_lat[i] : s[i];
        win = lowest(pend & m_en);
        acc = ack && m_irq && (win >= 0);
        m_ready = sel;
        m_rdata = 32'd0;
        if (sel && !wr) begin
            case (addr[3:2])
                2'd0:    m_rdata = 32'(m_en);
                2'd1:    m_rdata = 32'(pend);
                2'd2:    m_rdata = 32'(m_edge);
                default: m_rdata = {m_insvc, 26'd0, m_id};
            endcase
        end
        w1c = (sel && wr && addr[3:2] == 2'd1) ? wdata[NB-1:0] : 8'd0;
        chg = (sel && wr && addr[3:2] == 2'd2) ? (wdata[NB-1:0] ^ m_edge) : 8'd0;
        for (int i = 0; i < NB; i++) begin
            if (!m_edge[i] || chg[i])               nlat[i] = 1'b0;
            else if (s[i] && !m_prev[i])            nlat[i] = 1'b1;
            else if ((acc && win == i) || w1c[i])   nlat[i] = 1'b0;
            else                                    nlat[i] = m_lat[i];
        end
        m_irq = (win >= 0) && !m_insvc && !acc;
        if (acc) begin
            m_insvc = 1'b1;
            m_id    = 5'(win);
        end else if (eoi && m_insvc) begin
            m_insvc = 1'b0;
            m_id    = 5'd0;
        end
        if (sel && wr && addr[3:2] == 2'd0) m_en   = wdata[NB-1:0];
        if (sel && wr && addr[3:2] == 2'd2) m_edge = wdata[NB-1:0];
        m_lat  = nlat;
        m_prev = s;
        for (int k = SS-1; k > 0; k--) m_sync[k] = m_sync[k-1];
        m_sync[0] = src;
    endtask

    initial begin
        for (int k = 0; k < SS; k++) m_sync[k] = 8'd0;
        forever begin
            @(posedge clk or negedge rst_n);
            model_step();
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("model irq",   32'(irq),    32'(m_irq));
            chk("model id",    32'(irq_id), 32'(m_id));
            chk("model ready", 32'(ready),  32'(m_ready));
            chk("model rdata", rdata,       m_rdata);
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reg_wr(input logic [3:0] a, input logic [31:0] d);
        sel = 1'b1; wr = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        sel = 1'b0; wr = 1'b0; wdata = 32'd0;
    endtask

    task automatic reg_rd(input logic [3:0] a, output logic [31:0] d);
        sel = 1'b1; wr = 1'b0; addr = a;
        @(negedge clk);
        sel = 1'b0;
        d = rdata;
    endtask

    task automatic pulse_src(input logic [NB-1:0] m);
        src = m;
        @(negedge clk);
        src = 8'd0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic pulse_eoi();
        eoi = 1'b1;
        @(negedge clk);
        eoi = 1'b0;
    endtask

    initial begin
        // reset state
        tick(3);
        chk("reset irq",   32'(irq),    32'd0);
        chk("reset id",    32'(irq_id), 32'd0);
        chk("reset rdata", rdata,       32'd0);
        chk("reset ready", 32'(ready),  32'd0);
        rst_n = 1'b1;
        tick(1);

        // 1: single edge source, latency and accept
        reg_wr(4'h8, 32'h01);
        reg_wr(4'h0, 32'h01);
        pulse_src(8'h01);
        tick(2);
        chk("t1 irq before 4th edge", 32'(irq), 32'd0);
        tick(1);
        chk("t1 irq at 4th edge", 32'(irq), 32'd1);
        pulse_ack();
        chk("t1 irq after ack", 32'(irq), 32'd0);
        chk("t1 id", 32'(irq_id), 32'd0);
        reg_rd(4'hC, rd_val);
        chk("t1 ACTIVE", rd_val, 32'h8000_0000);
        reg_rd(4'h4, rd_val);
        chk("t1 PENDING", rd_val, 32'h0);
        pulse_eoi();

        // 2: priority between simultaneous edges
        reg_wr(4'h8, 32'h24);
        reg_wr(4'h0, 32'h24);
        pulse_src(8'h24);
        tick(3);
        chk("t2 irq", 32'(irq), 32'd1);
        pulse_ack();
        chk("t2 first id", 32'(irq_id), 32'd2);
        tick(1);
        pulse_eoi();
        chk("t2 irq on eoi edge", 32'(irq), 32'd0);
        tick(1);
        chk("t2 irq re-asserts", 32'(irq), 32'd1);
        pulse_ack();
        chk("t2 second id", 32'(irq_id), 32'd5);
        pulse_eoi();

        // 3: level source
        reg_wr(4'h8, 32'h00);
        reg_wr(4'h0, 32'h08);
        src = 8'h08;
        tick(4);
        chk("t3 irq level", 32'(irq), 32'd1);
        pulse_ack();
        chk("t3 id", 32'(irq_id), 32'd3);
        tick(1);
        pulse_eoi();
        tick(1);
        chk("t3 irq re-asserts", 32'(irq), 32'd1);
        src = 8'h00;
        tick(4);
        chk("t3 irq after drop", 32'(irq), 32'd0);
        pulse_ack();
        reg_rd(4'hC, rd_val);
        chk("t3 ACTIVE after stray ack", rd_val, 32'h0);

        // 4: masking retains pending, W1C clears it
        reg_wr(4'h8, 32'h02);
        reg_wr(4'h0, 32'h00);
        pulse_src(8'h02);
        tick(4);
        chk("t4 irq masked", 32'(irq), 32'd0);
        reg_rd(4'h4, rd_val);
        chk("t4 PENDING kept", rd_val, 32'h02);
        reg_wr(4'h0, 32'h02);
        tick(1);
        chk("t4 irq enabled", 32'(irq), 32'd1);
        reg_wr(4'h4, 32'h02);
        reg_rd(4'h4, rd_val);
        chk("t4 PENDING after W1C", rd_val, 32'h0);
        chk("t4 irq after W1C", 32'(irq), 32'd0);

        // 5: set wins over same-cycle W1C and ack
        reg_wr(4'h0, 32'h00);
        pulse_src(8'h02);
        tick(3);
        pulse_src(8'h02);
        tick(1);
        reg_wr(4'h4, 32'h02);
        reg_rd(4'h4, rd_val);
        chk("t5 W1C vs edge", rd_val, 32'h02);
        reg_wr(4'h0, 32'h02);
        tick(1);
        chk("t5 irq", 32'(irq), 32'd1);
        pulse_src(8'h02);
        tick(1);
        pulse_ack();
        chk("t5 id", 32'(irq_id), 32'd1);
        reg_rd(4'h4, rd_val);
        chk("t5 ack vs edge", rd_val, 32'h02);
        pulse_eoi();
        reg_wr(4'h4, 32'h02);

        // 6: reset in the middle of service
        reg_wr(4'h8, 32'hFF);
        reg_wr(4'h0, 32'hFF);
        pulse_src(8'hFF);
        tick(4);
        pulse_ack();
        pulse_src(8'hFF);
        tick(3);
        reg_rd(4'h4, rd_val);
        chk("t6 PENDING all", rd_val, 32'hFF);
        sel = 1'b1; wr = 1'b0; addr = 4'hC;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6 rst irq",   32'(irq),    32'd0);
        chk("t6 rst id",    32'(irq_id), 32'd0);
        chk("t6 rst rdata", rdata,       32'd0);
        chk("t6 rst ready", 32'(ready),  32'd0);
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        reg_rd(4'h0, rd_val);
        chk("t6 ENABLE after reset", rd_val, 32'h0);
        pulse_src(8'h01);
        tick(4);
        chk("t6 irq stays low", 32'(irq), 32'd0);

        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < NB; b++) begin
                if ($urandom_range(7) == 0) src[b] = ~src[b];
            end
            ack   = ($urandom_range(3) == 0);
            eoi   = ($urandom_range(5) == 0);
            sel   = ($urandom_range(2) == 0);
            wr    = 1'($urandom_range(1));
            addr  = 4'($urandom_range(15));
            wdata = $urandom;
            @(negedge clk);
        end
        src = 8'd0; ack = 1'b0; eoi = 1'b0; sel = 1'b0; wr = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
